axil_cfg_master: RTL and testbench
==================================

Name: axil_cfg_master

Overview:
- AXI4-Lite master that turns a simple command stream into single-beat AXI4-Lite write and read transactions.
- Drives the accelerator's register-mapped configuration slave, for example the soft reset, DDR offset, start and instruction-RAM load registers, and the status and debug readback registers.
- Sits between an on-chip sequencer or debug bridge and the slave.
- Exactly one transaction is in flight at a time.

Parameters:
- AXI4L_ADDR_WIDTH, 32, AXI4-Lite address width.
- AXI4L_DATA_WIDTH, 32, AXI4-Lite data width; strobe width is AXI4L_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, timeout limit. Used only with AXIL_MST_TIMEOUT_EN.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI4L_ADDR_WIDTH  byte address.
- cmd_wdata  in  AXI4L_DATA_WIDTH  write data.
- cmd_wstrb  in  AXI4L_DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  AXI4L_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_timeout  out  1  transaction abandoned by timeout.
- busy_out  out  1  high in every state except IDLE.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels. AWPROT and ARPROT are tied to 3'b000.

Behaviour:
- Reset: all outputs 0 and state is IDLE, applied asynchronously.
- Reset may be asserted mid-transaction; the bus is dropped immediately and no response is produced.
- cmd_ready equals (state == IDLE). It is a registered state decode and has no combinational path from cmd_valid.
- On accept, cmd_write, cmd_addr, cmd_wdata and cmd_wstrb are captured into registers.
- IDLE to W_AW if cmd_write = 1, otherwise IDLE to R_AR.
- W_AW:
  - awvalid and wvalid go high in the cycle after accept.
  - Each deasserts independently in the cycle after its own handshake (awvalid & awready, or wvalid & wready).
  - Either may complete first, and both may complete in the same cycle.
  - Move to W_B when both handshakes are done. Tracked with two done flags, which are cleared on command accept.
- W_B: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0, go to RSP. bready drops on exit.
- R_AR: arvalid high until arready, then go to R_D.
- R_D:
  - rready = 1.
  - On rvalid, capture rdata and rresp, go to RSP.
  - The slave may wait for rready before raising rvalid; that is legal and must not deadlock.
- RSP: rsp_valid = 1 and response fields held stable until rsp_ready; then go to IDLE.
  - The next command can be accepted in the cycle after the response is consumed.
- AXI rules:
  - No valid is deasserted before its handshake.
  - Address, data and strobe outputs are stable while their valid is high.
  - No combinational path from any AXI input to any AXI output.
- Minimum latency with a zero-wait slave and rsp_ready held high:
  - write: accept at cycle 0, awvalid/wvalid at cycle 1, bready at cycle 2, rsp_valid at cycle 3;
  - read: accept at cycle 0, arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- Non-OKAY responses (SLVERR, DECERR) are passed through in rsp_resp unmodified. There are no retries.

Optional Feature:
- Macro: AXIL_MST_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears on command accept and increments in W_AW, W_B, R_AR and R_D.
  - When it reaches TIMEOUT_CYCLES, all m_axi valid and ready outputs drop on the next edge.
  - The state goes to RSP with rsp_resp = 2'b10, rsp_timeout = 1 and rsp_rdata = 0.
  - This is a deliberate debug recovery that breaks the AXI protocol; the slave must be reset afterwards.
- Without the macro: no counter, the block waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write, zero-wait slave: cmd addr 0x04, data 0x1234_0000, strb 0xF -> awaddr 0x04 and wdata 0x1234_0000 at cycle 1, rsp_valid at cycle 3, rsp_resp 0, rsp_write 1.
- Slave awready at cycle 1 and wready 3 cycles later -> awvalid low from cycle 2, wvalid held until its handshake, exactly one B accepted, single response.
- Read addr 0x0C with the slave returning rdata 0x3 after rready has been high 4 cycles -> rsp_rdata 0x3, rsp_write 0, no deadlock.
- Back-to-back: write 0x20 then read 0x20 with rsp_ready high -> cmd_ready low during each transaction, second accept in the cycle after the first rsp handshake; bresp SLVERR injected on the write -> rsp_resp 2'b10.
- aresetn pulsed low while arvalid is high and arready held 0 -> arvalid, busy_out, rsp_valid = 0 immediately; the next command completes normally.
- With AXIL_MST_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never raises bvalid -> rsp_timeout 1, rsp_resp 2'b10, bready low; without the macro, busy_out stays high after 1000 cycles.

Source files
------------

// File: rtl/axil_cfg_master.sv
// AXI4-Lite configuration master: one command in, one single-beat write or read on the bus, one response out.
// Define AXIL_MST_TIMEOUT_EN to add a debug timeout that abandons a stuck transaction.
module axil_cfg_master #(
  parameter int AXI4L_ADDR_WIDTH = 32,
  parameter int AXI4L_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI4L_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI4L_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI4L_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [AXI4L_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          busy_out,
  output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI4L_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI4L_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI4L_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI4L_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int SW = AXI4L_DATA_WIDTH/8;

  typedef enum logic [2:0] {IDLE, W_AW, W_B, R_AR, R_D, RSP} state_t;

  typedef struct packed {
    logic                        write;
    logic [AXI4L_ADDR_WIDTH-1:0] addr;
    logic [AXI4L_DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]               wstrb;
  } cmd_t;

  typedef struct packed {
    logic [AXI4L_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  resp;
  } rsp_t;

  // Every handshake/valid output is a flop so no AXI input reaches an AXI output combinationally.
  typedef struct packed {
    logic cmd_ready;
    logic busy;
    logic awvalid;
    logic wvalid;
    logic bready;
    logic arvalid;
    logic rready;
    logic rsp_valid;
  } ctl_t;

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  ctl_t   ctl_q, ctl_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  assign accept = cmd_valid & ctl_q.cmd_ready;
  assign aw_hs  = ctl_q.awvalid & m_axi_awready;
  assign w_hs   = ctl_q.wvalid & m_axi_wready;
  assign b_hs   = ctl_q.bready & m_axi_bvalid;
  assign ar_hs  = ctl_q.arvalid & m_axi_arready;
  assign r_hs   = ctl_q.rready & m_axi_rvalid;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXIL_MST_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        cmd_d     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_write ? W_AW : R_AR;
      end
      W_AW: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = W_B;
      end
      W_B: if (b_hs) begin
        rsp_d.rdata = '0;
        rsp_d.resp  = m_axi_bresp;
        state_d     = RSP;
      end
      R_AR: if (ar_hs) state_d = R_D;
      R_D: if (r_hs) begin
        rsp_d.rdata = m_axi_rdata;
        rsp_d.resp  = m_axi_rresp;
        state_d     = RSP;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AXIL_MST_TIMEOUT_EN
    // Abandoning the bus here violates AXI on purpose; the slave needs a reset afterwards.
    if (state_q == IDLE) cnt_d = '0;
    if (accept) tmo_d = 1'b0;
    if (state_q inside {W_AW, W_B, R_AR, R_D}) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
        state_d     = RSP;
        rsp_d.rdata = '0;
        rsp_d.resp  = 2'b10;
        tmo_d       = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
    ctl_d.cmd_ready = (state_d == IDLE);
    ctl_d.busy      = (state_d != IDLE);
    ctl_d.awvalid   = (state_d == W_AW) && !aw_done_d;
    ctl_d.wvalid    = (state_d == W_AW) && !w_done_d;
    ctl_d.bready    = (state_d == W_B);
    ctl_d.arvalid   = (state_d == R_AR);
    ctl_d.rready    = (state_d == R_D);
    ctl_d.rsp_valid = (state_d == RSP);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rsp_q     <= '0;
      ctl_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rsp_q     <= rsp_d;
      ctl_q     <= ctl_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXIL_MST_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign rsp_timeout = tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = ctl_q.cmd_ready;
  assign busy_out      = ctl_q.busy;
  assign rsp_valid     = ctl_q.rsp_valid;
  assign rsp_write     = cmd_q.write;
  assign rsp_rdata     = rsp_q.rdata;
  assign rsp_resp      = rsp_q.resp;

  assign m_axi_awaddr  = cmd_q.addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = ctl_q.awvalid;
  assign m_axi_wdata   = cmd_q.wdata;
  assign m_axi_wstrb   = cmd_q.wstrb;
  assign m_axi_wvalid  = ctl_q.wvalid;
  assign m_axi_bready  = ctl_q.bready;
  assign m_axi_araddr  = cmd_q.addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = ctl_q.arvalid;
  assign m_axi_rready  = ctl_q.rready;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master: table of transactions against a delay-programmable slave, plus reset and hang sequences.
module tb_axil_cfg_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout, busy_out;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rvalid = 1'b0, m_axi_rready;

  always #5 aclk = ~aclk;

  axil_cfg_master #(.AXI4L_ADDR_WIDTH(AW), .AXI4L_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy_out(busy_out),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave delays: aw/w/ar ready after N cycles of valid, b after N cycles past both
  // address/data handshakes, r after rready has been high r_dly cycles.
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    int            exp_cyc, exp_a_hi, exp_w_hi;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  a_hi = 0, w_hi = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, perr = 0;
    int  both_cyc = -1, rr_cnt = 0, rsp_first = -1, rsp_hs_cyc = -1;
    bit  r_up = 0, aw_pend = 0, w_pend = 0, ar_pend = 0, rsp_pend = 0, done = 0;
    logic [1:0]    resp0 = '0;
    logic [DW-1:0] rd0 = '0;
    logic          wr0 = 1'b0, tmo0 = 1'b0;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rsp_idle"}, 64'(rsp_valid), 64'd0);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      if (cmd_ready || !busy_out) perr++;
      if ((aw_pend && !m_axi_awvalid) || (w_pend && !m_axi_wvalid) ||
          (ar_pend && !m_axi_arvalid) || (rsp_pend && !rsp_valid)) perr++;
      if (m_axi_awvalid) begin a_hi++; if (m_axi_awaddr != v.addr) perr++; end
      if (m_axi_wvalid) begin
        w_hi++;
        if (m_axi_wdata != v.wdata || m_axi_wstrb != v.wstrb) perr++;
      end
      if (m_axi_arvalid) begin a_hi++; if (m_axi_araddr != v.addr) perr++; end
      if (v.write ? (m_axi_arvalid || m_axi_rready) : (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) perr++;
      m_axi_awready = m_axi_awvalid && (cyc >= 1 + v.aw_dly);
      m_axi_wready  = m_axi_wvalid && (cyc >= 1 + v.w_dly);
      m_axi_bvalid  = (b_hs == 0) && (both_cyc > 0) && (cyc >= both_cyc + 1 + v.b_dly);
      m_axi_bresp   = m_axi_bvalid ? v.resp : ~v.resp;
      m_axi_arready = m_axi_arvalid && (cyc >= 1 + v.ar_dly);
      if (ar_hs > 0 && !r_up && m_axi_rready) begin
        if (rr_cnt == v.r_dly) r_up = 1; else rr_cnt++;
      end
      m_axi_rvalid = r_up && (r_hs == 0);
      m_axi_rdata  = m_axi_rvalid ? v.rdata : ~v.rdata;
      m_axi_rresp  = m_axi_rvalid ? v.resp : ~v.resp;
      if (rsp_valid) begin
        if (rsp_first < 0) begin
          rsp_first = cyc; resp0 = rsp_resp; rd0 = rsp_rdata; wr0 = rsp_write; tmo0 = rsp_timeout;
        end else if (rsp_resp != resp0 || rsp_rdata != rd0 || rsp_write != wr0) perr++;
        rsp_ready = (cyc >= rsp_first + v.rsp_dly);
      end else rsp_ready = 1'b0;
      if (m_axi_awvalid && m_axi_awready) aw_hs++;
      if (m_axi_wvalid && m_axi_wready) w_hs++;
      if (aw_hs > 0 && w_hs > 0 && both_cyc < 0) both_cyc = cyc;
      if (m_axi_bvalid && m_axi_bready) b_hs++;
      if (m_axi_arvalid && m_axi_arready) ar_hs++;
      if (m_axi_rvalid && m_axi_rready) r_hs++;
      aw_pend  = m_axi_awvalid && !m_axi_awready;
      w_pend   = m_axi_wvalid && !m_axi_wready;
      ar_pend  = m_axi_arvalid && !m_axi_arready;
      rsp_pend = rsp_valid && !rsp_ready;
      if (rsp_valid && rsp_ready) begin done = 1; rsp_hs_cyc = cyc; end
      @(negedge aclk);
    end
    slave_idle();
    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_rsp_cycle"}, 64'(rsp_first), 64'(v.exp_cyc));
    chk({tag, "_rsp_hs_cycle"}, 64'(rsp_hs_cyc), 64'(v.exp_cyc + v.rsp_dly));
    chk({tag, "_rsp_resp"}, 64'(resp0), 64'(v.exp_resp));
    chk({tag, "_rsp_rdata"}, 64'(rd0), 64'(v.exp_rdata));
    chk({tag, "_rsp_write"}, 64'(wr0), 64'(v.write));
    chk({tag, "_rsp_timeout"}, 64'(tmo0), 64'd0);
    chk({tag, "_addr_valid_cycles"}, 64'(a_hi), 64'(v.exp_a_hi));
    chk({tag, "_wvalid_cycles"}, 64'(w_hi), 64'(v.exp_w_hi));
    chk({tag, "_handshakes"}, {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0], r_hs[7:0]},
        v.write ? 64'h01_01_01_00_00 : 64'h00_00_00_01_01);
    chk({tag, "_protocol_errs"}, 64'(perr), 64'd0);
  endtask

  vec_t vecs[8];
  vec_t v_rec;

  initial begin
    //        wr    addr          wdata           strb   aw w  b  ar r  rsp resp   rdata           cyc ahi whi eresp  erdata
    vecs[0] = '{1'b1, 32'h0000_0004, 32'h1234_0000, 4'hF, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,          3, 1, 1, 2'd0, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 0, 3, 0, 0, 0, 0, 2'd0, 32'h0,          6, 1, 4, 2'd0, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hC, 2, 0, 1, 0, 0, 0, 2'd3, 32'h0,          6, 3, 1, 2'd3, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 0, 0, 4, 0, 2'd0, 32'h3,          7, 1, 0, 2'd0, 32'h3};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 32'hCAFE_F00D,  3, 1, 0, 2'd0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 0, 2, 1, 2, 2'd2, 32'h0000_55AA,  6, 3, 0, 2'd2, 32'h0000_55AA};
    vecs[6] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 0, 2'd2, 32'h0,          3, 1, 1, 2'd2, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0000_0001,  3, 1, 0, 2'd0, 32'h0000_0001};
    v_rec   = '{1'b1, 32'h0000_0004, 32'h0000_0001, 4'h1, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,          3, 1, 1, 2'd0, 32'h0};

    repeat (2) @(negedge aclk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_busy", 64'(busy_out), 64'd0);
    chk("reset_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 64'd0);
    chk("reset_axi_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
    chk("reset_axi_data", {m_axi_awaddr, m_axi_wdata}, 64'd0);
    chk("prot_tied", {m_axi_awprot, m_axi_arprot}, 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a read address is stalled.
    chk("rst_seq_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    @(negedge aclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_seq_arvalid_stalled", {m_axi_arvalid, busy_out}, 64'b11);
    aresetn = 1'b0;
    #1;
    chk("rst_seq_drop", {m_axi_arvalid, busy_out, rsp_valid, m_axi_rready, cmd_ready}, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    run_vec(v_rec, "after_rst");

    // Slave that never answers the write response.
    chk("hang_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 1'b0;
    chk("hang_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 64'b11);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge aclk);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("hang_bready", 64'(m_axi_bready), 64'd1);
`ifdef AXIL_MST_TIMEOUT_EN
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge aclk);
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_flag", 64'(rsp_timeout), 64'd1);
    chk("tmo_resp", 64'(rsp_resp), 64'd2);
    chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
    chk("tmo_bready_low", 64'(m_axi_bready), 64'd0);
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
`else
    repeat (1000) @(negedge aclk);
    chk("hang_busy_1000", {busy_out, m_axi_bready, rsp_valid, rsp_timeout}, 64'b1100);
`endif
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    run_vec(vecs[0], "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
